// File: rtl/tty_writer_pkg.sv
// Shared definitions for the text-mode console writer: FSM encoding,
// control codes and the row-offset helper used to form cell addresses.
package tty_writer_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PUT_C   = 3'd2,
    ST_PUT_A   = 3'd3,
    ST_SCR_RD  = 3'd4,
    ST_SCR_WR  = 3'd5,
    ST_SCR_CLR = 3'd6
  } tty_state_e;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // y*cols in cells; the 80-column case uses (y<<6)+(y<<4) to avoid a multiplier.
  function automatic logic [11:0] row_offset(input logic [4:0] y, input int cols);
    logic [11:0] yw;
    yw = {7'd0, y};
    if (cols == 80) begin
      return (yw << 6) + (yw << 4);
    end
    return yw * 12'(cols);
  endfunction

endpackage

// File: rtl/tty_writer.sv
// Console writer: turns a byte stream (with CR/LF/BS) into char/attr writes on
// the write port of the video RAM, including line wrap and one-row scrolling.
module tty_writer
  import tty_writer_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter logic [7:0] CLEAR_ATTR = 8'h07
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  output logic        in_ready,
  output logic [11:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [11:0] TOTAL     = 12'(COLS * ROWS * 2);
  localparam logic [11:0] LAST      = 12'(COLS * ROWS * 2 - 1);
  localparam logic [11:0] ROW_BYTES = 12'(COLS * 2);
  localparam logic [11:0] LAST_ROW  = 12'((ROWS - 1) * COLS * 2);
  localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
  localparam logic [4:0]  Y_MAX     = 5'(ROWS - 1);

  tty_state_e  state_q;
  logic [11:0] addr_q;
  logic [7:0]  wdata_q;
  logic        we_q;
  logic [11:0] ptr_q;
  logic [6:0]  x_q;
  logic [4:0]  y_q;
  logic [7:0]  attr_q;
  logic [11:0] cell_addr_d;

  always_comb begin
    cell_addr_d = (row_offset(y_q, COLS) + {5'd0, x_q}) << 1;
  end

  // Handshake: a byte moves on a rising edge where in_valid and in_ready are
  // both high; in_ready is high only in IDLE and the source holds data until then.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ptr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      attr_q  <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (ptr_q == TOTAL) begin
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            addr_q  <= ptr_q;
            wdata_q <= ptr_q[0] ? CLEAR_ATTR : CH_SPACE;
            we_q    <= 1'b1;
            ptr_q   <= ptr_q + 12'd1;
          end
        end

        ST_IDLE: begin
          we_q <= 1'b0;
          if (in_valid) begin
            case (in_char)
              CH_CR: x_q <= '0;
              CH_BS: begin
                if (x_q != 7'd0) x_q <= x_q - 7'd1;
              end
              CH_LF: begin
                if (y_q != Y_MAX) begin
                  y_q <= y_q + 5'd1;
                end else begin
                  ptr_q   <= ROW_BYTES;
                  addr_q  <= ROW_BYTES;
                  state_q <= ST_SCR_RD;
                end
              end
              default: begin
                attr_q  <= in_attr;
                addr_q  <= cell_addr_d;
                wdata_q <= in_char;
                we_q    <= 1'b1;
                state_q <= ST_PUT_C;
              end
            endcase
          end
        end

        ST_PUT_C: begin
          addr_q  <= addr_q + 12'd1;
          wdata_q <= attr_q;
          state_q <= ST_PUT_A;
        end

        ST_PUT_A: begin
          we_q <= 1'b0;
          if (x_q == X_MAX) begin
            x_q <= '0;
            if (y_q != Y_MAX) begin
              y_q     <= y_q + 5'd1;
              state_q <= ST_IDLE;
            end else begin
              ptr_q   <= ROW_BYTES;
              addr_q  <= ROW_BYTES;
              state_q <= ST_SCR_RD;
            end
          end else begin
            x_q     <= x_q + 7'd1;
            state_q <= ST_IDLE;
          end
        end

        // Read byte s, then write it one row up; the write data is the RAM's
        // registered read data, which is valid during SCR_WR.
        ST_SCR_RD: begin
          addr_q  <= ptr_q - ROW_BYTES;
          we_q    <= 1'b1;
          state_q <= ST_SCR_WR;
        end

        ST_SCR_WR: begin
          if (ptr_q == LAST) begin
            ptr_q   <= LAST_ROW;
            addr_q  <= LAST_ROW;
            wdata_q <= CH_SPACE;
            state_q <= ST_SCR_CLR;
          end else begin
            ptr_q   <= ptr_q + 12'd1;
            addr_q  <= ptr_q + 12'd1;
            we_q    <= 1'b0;
            state_q <= ST_SCR_RD;
          end
        end

        ST_SCR_CLR: begin
          if (ptr_q == LAST) begin
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            ptr_q   <= ptr_q + 12'd1;
            addr_q  <= ptr_q + 12'd1;
            wdata_q <= ptr_q[0] ? CH_SPACE : CLEAR_ATTR;
          end
        end

        default: begin
          we_q    <= 1'b0;
          ptr_q   <= '0;
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign mem_address = addr_q;
  assign mem_we      = we_q;
  assign mem_wdata   = (state_q == ST_SCR_WR) ? mem_rdata : wdata_q;
  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign dbg_state   = state_q;

endmodule
